// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU core: unit codes, per-unit operations and FSM states.
package alu_seq_pkg;

    localparam logic [1:0] UNIT_ARI = 2'b00;
    localparam logic [1:0] UNIT_LOG = 2'b01;
    localparam logic [1:0] UNIT_CMP = 2'b10;
    localparam logic [1:0] UNIT_SHF = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    localparam logic [1:0] OP_EQ = 2'b00;
    localparam logic [1:0] OP_GT = 2'b01;
    localparam logic [1:0] OP_LT = 2'b10;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SLA = 2'b01;
    localparam logic [1:0] OP_SRB = 2'b10;
    localparam logic [1:0] OP_SLB = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one step per cycle over WID cycles.
// Divider logic exists only when ALU_SEQ_DIV_EN is defined; otherwise DIV starts are ignored.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WID = 16,
    parameter int CW  = 5
) (
    input  logic           clk,
    input  logic           rest,
    input  logic           start_i,
    input  logic [1:0]     op_i,
    input  logic [WID-1:0] a_i,
    input  logic [WID-1:0] b_i,
    output logic           done_o,
    output logic [WID-1:0] hi_o,
    output logic [WID-1:0] lo_o,
    output logic           div0_o
);

    logic           busy_q;
    logic           done_q;
    logic [CW-1:0]  cnt_q;
    logic [WID-1:0] hi_q, lo_q, b_q;
    logic [WID-1:0] hi_d, lo_d;
    logic [WID:0]   mul_sum;
    logic           go;

`ifdef ALU_SEQ_DIV_EN
    logic           is_div_q;
    logic           div0_q;
    logic [WID:0]   div_trial;
    assign go     = start_i && ((op_i == OP_MUL) || (op_i == OP_DIV));
    assign div0_o = div0_q;
`else
    assign go     = start_i && (op_i == OP_MUL);
    assign div0_o = 1'b0;
`endif

    // hi/lo double as accumulator/multiplier for MUL and remainder/quotient for DIV.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        hi_d    = mul_sum[WID:1];
        lo_d    = {mul_sum[0], lo_q[WID-1:1]};
`ifdef ALU_SEQ_DIV_EN
        div_trial = {hi_q, lo_q[WID-1]} - {1'b0, b_q};
        if (is_div_q) begin
            if (!div_trial[WID]) begin
                hi_d = div_trial[WID-1:0];
                lo_d = {lo_q[WID-2:0], 1'b1};
            end else begin
                hi_d = {hi_q[WID-2:0], lo_q[WID-1]};
                lo_d = {lo_q[WID-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
`ifdef ALU_SEQ_DIV_EN
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (go) begin
                busy_q <= 1'b1;
                cnt_q  <= '0;
                hi_q   <= '0;
                lo_q   <= a_i;
                b_q    <= b_i;
`ifdef ALU_SEQ_DIV_EN
                is_div_q <= (op_i == OP_DIV);
                div0_q   <= (op_i == OP_DIV) && (b_i == '0);
`endif
            end else if (busy_q) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(WID - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU top: input/output valid-ready handshakes, IDLE/BUSY FSM and single-cycle units.
// Define ALU_SEQ_DIV_EN to build the iterative divider; otherwise DIV is a 1-cycle illegal-op marker.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WID = 16,
    parameter int CW  = 5
) (
    input  logic           clk,
    input  logic           rest,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WID-1:0] A,
    input  logic [WID-1:0] B,
    input  logic [3:0]     alu_fun,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WID-1:0] result,
    output logic [WID-1:0] result_hi,
    output logic           carry_out,
    output logic           zero_flag,
    output logic           div0_flag,
    output logic [1:0]     unit_sel
);

    state_e         state_q;
    logic           out_valid_q, carry_q, zero_q, div0_q;
    logic [WID-1:0] result_q, hi_q;
    logic [1:0]     unit_q;

    logic [WID-1:0] sc_res, sc_hi;
    logic           sc_carry, sc_div0, is_multi;
    logic           accept;
    logic           md_done, md_div0;
    logic [WID-1:0] md_hi, md_lo;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !rest;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sc_res   = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_div0  = 1'b0;
        is_multi = 1'b0;
        case (alu_fun[3:2])
            UNIT_ARI: begin
                case (alu_fun[1:0])
                    OP_ADD:  {sc_carry, sc_res} = {1'b0, A} + {1'b0, B};
                    OP_SUB: begin
                        sc_res   = A - B;
                        sc_carry = (A < B);
                    end
                    OP_MUL:  is_multi = 1'b1;
`ifdef ALU_SEQ_DIV_EN
                    default: is_multi = 1'b1;
`else
                    default: sc_div0 = 1'b1;
`endif
                endcase
            end
            UNIT_LOG: begin
                case (alu_fun[1:0])
                    OP_AND:  sc_res = A & B;
                    OP_OR:   sc_res = A | B;
                    OP_NAND: sc_res = ~(A & B);
                    default: sc_res = ~(A | B);
                endcase
            end
            UNIT_CMP: begin
                case (alu_fun[1:0])
                    OP_EQ:   sc_res[0] = (A == B);
                    OP_GT:   sc_res[0] = (A > B);
                    OP_LT:   sc_res[0] = (A < B);
                    default: sc_res = '0;
                endcase
            end
            default: begin
                case (alu_fun[1:0])
                    OP_SRA:  sc_res = A >> 1;
                    OP_SLA:  sc_res = A << 1;
                    OP_SRB:  sc_res = B >> 1;
                    default: sc_res = B << 1;
                endcase
            end
        endcase
    end

    alu_seq_muldiv #(
        .WID (WID),
        .CW  (CW)
    ) u_muldiv (
        .clk     (clk),
        .rest    (rest),
        .start_i (accept && is_multi),
        .op_i    (alu_fun[1:0]),
        .a_i     (A),
        .b_i     (B),
        .done_o  (md_done),
        .hi_o    (md_hi),
        .lo_o    (md_lo),
        .div0_o  (md_div0)
    );

    // A drain and a new single-cycle load may coincide; the later load wins out_valid.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            div0_q      <= 1'b0;
            unit_q      <= '0;
        end else begin
            if (out_valid_q && out_ready)
                out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_multi) begin
                            state_q <= ST_BUSY;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= sc_res;
                            hi_q        <= sc_hi;
                            carry_q     <= sc_carry;
                            zero_q      <= (sc_res == '0);
                            div0_q      <= sc_div0;
                            unit_q      <= alu_fun[3:2];
                        end
                    end
                end
                ST_BUSY: begin
                    if (md_done) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b1;
                        result_q    <= md_lo;
                        hi_q        <= md_hi;
                        carry_q     <= 1'b0;
                        zero_q      <= (md_lo == '0);
                        div0_q      <= md_div0;
                        unit_q      <= UNIT_ARI;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = hi_q;
    assign carry_out = carry_q;
    assign zero_flag = zero_q;
    assign div0_flag = div0_q;
    assign unit_sel  = unit_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core with a scoreboard of model results; follows ALU_SEQ_DIV_EN.
module tb_alu_seq_core;

    localparam int WID = 16;

    localparam logic [3:0] FUN_ADD  = 4'h0;
    localparam logic [3:0] FUN_SUB  = 4'h1;
    localparam logic [3:0] FUN_MUL  = 4'h2;
    localparam logic [3:0] FUN_DIV  = 4'h3;
    localparam logic [3:0] FUN_AND  = 4'h4;
    localparam logic [3:0] FUN_OR   = 4'h5;
    localparam logic [3:0] FUN_NAND = 4'h6;
    localparam logic [3:0] FUN_NOR  = 4'h7;
    localparam logic [3:0] FUN_EQ   = 4'h8;
    localparam logic [3:0] FUN_GT   = 4'h9;
    localparam logic [3:0] FUN_LT   = 4'hA;
    localparam logic [3:0] FUN_CMPX = 4'hB;
    localparam logic [3:0] FUN_SRA  = 4'hC;
    localparam logic [3:0] FUN_SLA  = 4'hD;
    localparam logic [3:0] FUN_SRB  = 4'hE;
    localparam logic [3:0] FUN_SLB  = 4'hF;

    typedef struct packed {
        logic [WID-1:0] res;
        logic [WID-1:0] hi;
        logic           carry;
        logic           zero;
        logic           div0;
        logic [1:0]     unit;
    } exp_t;

    logic           clk = 1'b0;
    logic           rest = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [WID-1:0] A = '0;
    logic [WID-1:0] B = '0;
    logic [3:0]     alu_fun = '0;
    logic           in_ready, out_valid, carry_out, zero_flag, div0_flag;
    logic [WID-1:0] result, result_hi;
    logic [1:0]     unit_sel;

    exp_t sbq[$];
    int   testCount = 0;
    int   failCount = 0;

    always #5 clk = ~clk;

    alu_seq_core #(.WID(WID), .CW(5)) dut (
        .clk       (clk),
        .rest      (rest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .alu_fun   (alu_fun),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .carry_out (carry_out),
        .zero_flag (zero_flag),
        .div0_flag (div0_flag),
        .unit_sel  (unit_sel)
    );

    function automatic exp_t modelOp(input logic [WID-1:0] a, input logic [WID-1:0] b,
                                     input logic [3:0] f);
        exp_t             e;
        logic [WID:0]     s;
        logic [2*WID-1:0] p;
        e = '0;
        case (f)
            FUN_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[WID-1:0];
                e.carry = s[WID];
            end
            FUN_SUB: begin
                e.res = a - b;
                e.carry = (a < b);
            end
            FUN_MUL: begin
                p = (2*WID)'(a) * (2*WID)'(b);
                e.res = p[WID-1:0];
                e.hi = p[2*WID-1:WID];
            end
            FUN_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                if (b == '0) begin
                    e.res = '1;
                    e.hi = a;
                    e.div0 = 1'b1;
                end else begin
                    e.res = a / b;
                    e.hi = a % b;
                end
`else
                e.div0 = 1'b1;
`endif
            end
            FUN_AND:  e.res = a & b;
            FUN_OR:   e.res = a | b;
            FUN_NAND: e.res = ~(a & b);
            FUN_NOR:  e.res = ~(a | b);
            FUN_EQ:   e.res[0] = (a == b);
            FUN_GT:   e.res[0] = (a > b);
            FUN_LT:   e.res[0] = (a < b);
            FUN_CMPX: e.res = '0;
            FUN_SRA:  e.res = a >> 1;
            FUN_SLA:  e.res = a << 1;
            FUN_SRB:  e.res = b >> 1;
            default:  e.res = b << 1;
        endcase
        e.zero = (e.res == '0);
        e.unit = f[3:2];
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: drains are compared before the same-cycle accept is queued.
    always @(negedge clk) begin
        exp_t e;
        if (!rest) begin
            if (out_valid && out_ready) begin
                checkOutput("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    checkOutput("sb_result", 32'(result), 32'(e.res));
                    checkOutput("sb_result_hi", 32'(result_hi), 32'(e.hi));
                    checkOutput("sb_carry", 32'(carry_out), 32'(e.carry));
                    checkOutput("sb_zero", 32'(zero_flag), 32'(e.zero));
                    checkOutput("sb_div0", 32'(div0_flag), 32'(e.div0));
                    checkOutput("sb_unit", 32'(unit_sel), 32'(e.unit));
                end
            end
            if (in_valid && in_ready)
                sbq.push_back(modelOp(A, B, alu_fun));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [WID-1:0] a, input logic [WID-1:0] b,
                                 input logic [3:0] f);
        bit done;
        done = 1'b0;
        A = a;
        B = b;
        alu_fun = f;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        A = ~a;
        B = ~b;
        checkOutput("accept_in_time", 32'(done), 32'd1);
    endtask

    task automatic waitResult(input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checkOutput("result_in_time", 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_flags", 32'({carry_out, zero_flag, div0_flag, unit_sel}), 32'd0);
        tick();
        rest = 1'b0;
        out_ready = 1'b1;

        applyStimulus(16'hFFFF, 16'h0001, FUN_ADD);
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_result", 32'(result), 32'd0);
        checkOutput("add_carry", 32'(carry_out), 32'd1);
        checkOutput("add_zero", 32'(zero_flag), 32'd1);

        A = 16'd3; B = 16'd5; alu_fun = FUN_SUB; in_valid = 1'b1;
        #1;
        checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("sub_valid", 32'(out_valid), 32'd1);
        checkOutput("sub_result", 32'(result), 32'h0000FFFE);
        checkOutput("sub_borrow", 32'(carry_out), 32'd1);
        A = 16'hF0F0; B = 16'hFF00; alu_fun = FUN_AND;
        tick();
        checkOutput("and_valid", 32'(out_valid), 32'd1);
        checkOutput("and_result", 32'(result), 32'h0000F000);
        A = 16'h0000; B = 16'h0000; alu_fun = FUN_NOR;
        tick();
        checkOutput("nor_result", 32'(result), 32'h0000FFFF);
        in_valid = 1'b0;
        tick();
        checkOutput("b2b_drained", 32'(out_valid), 32'd0);

        applyStimulus(16'd5, 16'd5, FUN_EQ);
        applyStimulus(16'd5, 16'd6, FUN_EQ);
        applyStimulus(16'd3, 16'd9, FUN_LT);
        applyStimulus(16'd3, 16'd9, FUN_GT);
        applyStimulus(16'd7, 16'd7, FUN_CMPX);
        applyStimulus(16'h0F00, 16'h00F0, FUN_OR);
        applyStimulus(16'hFFFF, 16'hFFFF, FUN_NAND);
        applyStimulus(16'h8001, 16'h0000, FUN_SRA);
        applyStimulus(16'h8001, 16'h0000, FUN_SLA);
        applyStimulus(16'h0000, 16'h0003, FUN_SRB);
        applyStimulus(16'h0000, 16'h8000, FUN_SLB);
        tick();

        applyStimulus(16'h1234, 16'h0100, FUN_MUL);
        for (int k = 1; k <= 17; k++) begin
            tick();
            checkOutput("mul_latency_valid", 32'(out_valid), 32'(k == 17));
            if (k < 17) checkOutput("mul_busy_in_ready", 32'(in_ready), 32'd0);
        end
        checkOutput("mul_product", {result_hi, result}, 32'h00123400);
        checkOutput("mul_carry", 32'(carry_out), 32'd0);
        tick();

        applyStimulus(16'd100, 16'd7, FUN_DIV);
`ifdef ALU_SEQ_DIV_EN
        checkOutput("div_not_yet", 32'(out_valid), 32'd0);
        waitResult(40);
        checkOutput("div_quot", 32'(result), 32'd14);
        checkOutput("div_rem", 32'(result_hi), 32'd2);
        checkOutput("div_div0", 32'(div0_flag), 32'd0);
`else
        checkOutput("div_1cycle", 32'(out_valid), 32'd1);
        waitResult(40);
        checkOutput("div_off_result", 32'(result), 32'd0);
        checkOutput("div_off_div0", 32'(div0_flag), 32'd1);
`endif
        tick();

        applyStimulus(16'd5, 16'd0, FUN_DIV);
        waitResult(40);
`ifdef ALU_SEQ_DIV_EN
        checkOutput("div0_result", 32'(result), 32'h0000FFFF);
        checkOutput("div0_rem", 32'(result_hi), 32'd5);
`else
        checkOutput("div0_result", 32'(result), 32'd0);
        checkOutput("div0_rem", 32'(result_hi), 32'd0);
`endif
        checkOutput("div0_flag", 32'(div0_flag), 32'd1);
        tick();

        out_ready = 1'b0;
        applyStimulus(16'd9, 16'd4, FUN_GT);
        A = 16'd2; B = 16'd3; alu_fun = FUN_ADD; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_result", 32'(result), 32'd1);
            checkOutput("bp_unit", 32'(unit_sel), 32'd2);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_next_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_next_result", 32'(result), 32'd5);
        tick();

        applyStimulus(16'h1234, 16'h5678, FUN_MUL);
        repeat (8) tick();
        rest = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst_result", {result_hi, result}, 32'd0);
        checkOutput("midrst_flags", 32'({carry_out, zero_flag, div0_flag, unit_sel}), 32'd0);
        sbq.delete();
        tick();
        rest = 1'b0;
        tick();
        applyStimulus(16'd2, 16'd2, FUN_ADD);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
        checkOutput("post_rst_result", 32'(result), 32'd4);
        checkOutput("post_rst_hi", 32'(result_hi), 32'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            checkOutput("no_leftover_mul", 32'(out_valid), 32'd0);
            tick();
        end

        checkOutput("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
